spi_cmd_controller: RTL and testbench
=====================================

Name: spi_cmd_controller

Overview:
- Command/register controller behind the byte-level SPI slave, clocked by SCLK only.
- Decodes the first byte of each SS-framed transaction as a command, then sequences write-data or read-data bytes.
- Owns a small configuration register file and a read-only status window.
- Drives the slave's transmit byte and receives its received byte and valid pulse.

Parameters:
- ADDR_W, 4, address width; register space is 2^ADDR_W bytes.
- NUM_RW, 8, number of writable config registers at addresses 0..NUM_RW-1. Addresses NUM_RW..2^ADDR_W-1 are read-only status.
- RST_VAL, 8'h00, reset value of every config register.

Ports:
- SCLK  in  1  SPI clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-high reset.
- SS  in  1  slave select, active low, sampled on posedge SCLK.
- rx_data  in  8  byte from the SPI slave.
- rx_valid  in  1  one-SCLK pulse; rx_data is valid this cycle.
- status_in  in  8*(2^ADDR_W-NUM_RW)  read-only bytes, lowest byte at address NUM_RW.
- tx_data  out  8  byte for the SPI slave to shift out on MISO.
- cfg_out  out  8*NUM_RW  flattened config registers; reg 0 is in bits [7:0].
- wr_strobe  out  1  one-cycle pulse when a config register is written.
- wr_addr  out  ADDR_W  address of the last write; valid while wr_strobe is high.
- busy  out  1  high while state is not IDLE.
- err  out  1  sticky error flag.

Behaviour:
- Reset (async): state=IDLE, all config regs=RST_VAL, tx_data=0, wr_strobe=0, wr_addr=0, err=0, internal addr=0.
- Command byte format: bit7 = W (1 write, 0 read); bit6 = INC (auto-increment); bits[ADDR_W-1:0] = address; remaining bits ignored.
- Any posedge with SS=1 forces state=IDLE and tx_data=0. Config regs and err are kept. wr_strobe=0.
  - This aborts a frame mid-operation; a partially shifted byte never produces rx_valid, so nothing is written.
- States and transitions (evaluated on posedge with SS=0 and rx_valid=1; with rx_valid=0 the state holds):
  - IDLE: latch addr from the byte. W=1 -> WR_DATA. W=0 -> RD_TURN, and tx_data <= byte at addr.
  - WR_DATA:
    - If addr<NUM_RW: reg[addr] <= rx_data, wr_strobe=1 for this cycle, wr_addr=addr.
    - Else the write is dropped, err <= 1, and no strobe is issued.
    - If INC: addr <= addr+1 modulo 2^ADDR_W (wraps to 0). Otherwise addr holds and repeated bytes rewrite the same register.
    - State stays WR_DATA.
  - RD_TURN: the first byte after the command is a turnaround. The master must send a dummy byte; its MISO content is undefined.
    - If INC: addr <= addr+1 and tx_data <= byte at addr+1.
    - State -> RD_DATA.
  - RD_DATA: each received byte is ignored. If INC, advance addr and load tx_data from the new addr; otherwise tx_data holds. State stays RD_DATA.
- Read data placement: read byte k (k=0,1,..) appears on MISO during frame byte 2+k, counting the command as byte 0.
- tx_data changes only on a posedge where rx_valid=1 or SS=1.
- Read mux: addr<NUM_RW returns reg[addr]; otherwise it returns status_in byte (addr-NUM_RW), sampled at the load edge.
- A write is visible on cfg_out the cycle after the edge that writes it. A read of the same register in a later frame returns the new value.
- busy = (state != IDLE), registered.
- err is cleared only by RESET.

Test Plan:
- Reset, then frame {0xC2,0x11,0x22,0x33} (write, INC, addr 2) -> regs 2,3,4 = 0x11,0x22,0x33; three wr_strobe pulses with wr_addr 2,3,4; err=0.
- Frame {0x42,0x00,0x00,0x00,0x00} after the previous write -> MISO bytes 2..4 = 0x11,0x22,0x33.
- Frame {0x8F,0x55} with NUM_RW=8 (write to RO addr 15) -> no strobe, no reg change, err=1. err stays 1 across later frames until RESET.
- Write wrap: frame {0xC7,0xA1,0xB2} -> reg7=0xA1; the write to addr 8 is dropped and sets err. Separately, a read with INC from addr 15 wraps to addr 0.
- Frame {0x09,0x00,0x00} with status_in byte1=0x5A -> MISO byte 2 = 0x5A. The same frame with INC clear and extra bytes -> 0x5A repeated.
- Abort: raise SS after 4 bits of the data byte in {0x81,...} -> reg1 unchanged, busy=0 at the next SCLK edge. Assert RESET mid-frame -> all regs=RST_VAL, tx_data=0.

Source files
------------

// File: rtl/spi_cmd_controller.sv
// Command/register controller behind a byte-level SPI slave.
// Decodes a command byte per SS frame, then sequences config writes or register/status reads.
module spi_cmd_controller #(
   parameter int          ADDR_W  = 4,
   parameter int          NUM_RW  = 8,
   parameter logic [7:0]  RST_VAL = 8'h00
) (
   input  logic                                  SCLK,
   input  logic                                  RESET,
   input  logic                                  SS,
   input  logic [7:0]                            rx_data,
   input  logic                                  rx_valid,
   input  logic [8*((1<<ADDR_W)-NUM_RW)-1:0]     status_in,
   output logic [7:0]                            tx_data,
   output logic [8*NUM_RW-1:0]                   cfg_out,
   output logic                                  wr_strobe,
   output logic [ADDR_W-1:0]                     wr_addr,
   output logic                                  busy,
   output logic                                  err
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] NUM_RW_W = (ADDR_W+1)'(NUM_RW);

   typedef enum logic [1:0] {IDLE, WR_DATA, RD_TURN, RD_DATA} state_t;

   state_t              state_reg, state_next;
   logic [ADDR_W-1:0]   addr_reg, addr_next;
   logic                inc_reg, inc_next;
   logic [7:0]          tx_reg, tx_next;
   logic                err_reg, err_next;
   logic                wr_strobe_reg, wr_strobe_next;
   logic [ADDR_W-1:0]   wr_addr_reg, wr_addr_next;
   logic                wr_en;

   logic [8*DEPTH-1:0]  space_flat;
   logic [ADDR_W-1:0]   addr_inc;
   logic [7:0]          rd_cmd, rd_inc;
   logic                addr_rw;

   // Whole address space as one flat byte vector: config regs below NUM_RW, status above.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_byte
         if (gi < NUM_RW) begin : g_rw
            logic [7:0] cfg_reg;
            always_ff @(posedge SCLK or posedge RESET) begin
               if (RESET)
                  cfg_reg <= RST_VAL;
               else if (wr_en && addr_reg == ADDR_W'(gi))
                  cfg_reg <= rx_data;
            end
            assign space_flat[8*gi +: 8] = cfg_reg;
            assign cfg_out[8*gi +: 8]    = cfg_reg;
         end else begin : g_ro
            assign space_flat[8*gi +: 8] = status_in[8*(gi-NUM_RW) +: 8];
         end
      end
   endgenerate

   assign addr_inc = addr_reg + ADDR_W'(1);
   assign rd_cmd   = space_flat[{rx_data[ADDR_W-1:0], 3'b000} +: 8];
   assign rd_inc   = space_flat[{addr_inc, 3'b000} +: 8];
   assign addr_rw  = ({1'b0, addr_reg} < NUM_RW_W);

   always_comb begin
      state_next     = state_reg;
      addr_next      = addr_reg;
      inc_next       = inc_reg;
      tx_next        = tx_reg;
      err_next       = err_reg;
      wr_strobe_next = 1'b0;
      wr_addr_next   = wr_addr_reg;
      wr_en          = 1'b0;
      if (SS) begin
         state_next = IDLE;
         tx_next    = 8'h00;
      end else if (rx_valid) begin
         case (state_reg)
            IDLE: begin
               addr_next = rx_data[ADDR_W-1:0];
               inc_next  = rx_data[6];
               if (rx_data[7]) begin
                  state_next = WR_DATA;
               end else begin
                  state_next = RD_TURN;
                  tx_next    = rd_cmd;
               end
            end
            WR_DATA: begin
               if (addr_rw) begin
                  wr_en          = 1'b1;
                  wr_strobe_next = 1'b1;
                  wr_addr_next   = addr_reg;
               end else begin
                  err_next = 1'b1;
               end
               if (inc_reg)
                  addr_next = addr_inc;
            end
            // Turnaround and data bytes behave alike: the load lands two bytes later on MISO.
            RD_TURN, RD_DATA: begin
               if (inc_reg) begin
                  addr_next = addr_inc;
                  tx_next   = rd_inc;
               end
               state_next = RD_DATA;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge SCLK or posedge RESET) begin
      if (RESET) begin
         state_reg     <= IDLE;
         addr_reg      <= '0;
         inc_reg       <= 1'b0;
         tx_reg        <= 8'h00;
         err_reg       <= 1'b0;
         wr_strobe_reg <= 1'b0;
         wr_addr_reg   <= '0;
      end else begin
         state_reg     <= state_next;
         addr_reg      <= addr_next;
         inc_reg       <= inc_next;
         tx_reg        <= tx_next;
         err_reg       <= err_next;
         wr_strobe_reg <= wr_strobe_next;
         wr_addr_reg   <= wr_addr_next;
      end
   end

   assign tx_data   = tx_reg;
   assign wr_strobe = wr_strobe_reg;
   assign wr_addr   = wr_addr_reg;
   assign err       = err_reg;
   assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_spi_cmd_controller.sv
// Scoreboard bench for spi_cmd_controller: stimulus pushes expected writes and tx bytes,
// a negedge monitor pops and compares them as the DUT presents strobes and tx updates.
module tb_spi_cmd_controller;

   localparam int ADDR_W = 4;
   localparam int NUM_RW = 8;
   localparam int DC     = -1;

   logic                SCLK = 1'b0;
   logic                RESET;
   logic                SS;
   logic [7:0]          rx_data;
   logic                rx_valid;
   logic [63:0]         status_in;
   logic [7:0]          tx_data;
   logic [8*NUM_RW-1:0] cfg_out;
   logic                wr_strobe;
   logic [ADDR_W-1:0]   wr_addr;
   logic                busy;
   logic                err;

   spi_cmd_controller #(.ADDR_W(ADDR_W), .NUM_RW(NUM_RW), .RST_VAL(8'h00)) dut (
      .SCLK      (SCLK),
      .RESET     (RESET),
      .SS        (SS),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .status_in (status_in),
      .tx_data   (tx_data),
      .cfg_out   (cfg_out),
      .wr_strobe (wr_strobe),
      .wr_addr   (wr_addr),
      .busy      (busy),
      .err       (err)
   );

   always #5 SCLK = ~SCLK;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [3:0] a;
      logic [7:0] d;
   } wr_t;

   wr_t  wr_q[$];
   int   tx_q[$];
   wr_t  w;
   int   e;
   logic seen_rx = 1'b0;

   always @(posedge SCLK or posedge RESET) begin
      if (RESET) seen_rx <= 1'b0;
      else       seen_rx <= rx_valid & ~SS;
   end

   // Monitor: one line per observed transaction.
   always @(negedge SCLK) begin
      if (wr_strobe) begin
         total++;
         if (wr_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_strobe: wr_addr=%0d got strobe, required none", wr_addr);
         end else begin
            w = wr_q.pop_front();
            if (wr_addr !== w.a || cfg_out[8*w.a +: 8] !== w.d) begin
               bad++;
               $display("FAIL write: got addr=%0d data=%02h, required addr=%0d data=%02h",
                        wr_addr, cfg_out[8*w.a +: 8], w.a, w.d);
            end else begin
               $display("write addr=%0d data=%02h ok", w.a, w.d);
            end
         end
      end
      if (seen_rx) begin
         if (tx_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL tx_unexpected: byte seen with no expectation, tx=%02h", tx_data);
         end else begin
            e = tx_q.pop_front();
            if (e >= 0) begin
               total++;
               if (tx_data !== e[7:0]) begin
                  bad++;
                  $display("FAIL tx: got %02h, required %02h", tx_data, e[7:0]);
               end else begin
                  $display("byte tx=%02h ok", tx_data);
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end else begin
         $display("check %s = %0h ok", name, act);
      end
   endtask

   task automatic send(input logic [7:0] b, input int exp_tx);
      @(negedge SCLK);
      rx_data  = b;
      rx_valid = 1'b1;
      tx_q.push_back(exp_tx);
      @(negedge SCLK);
      rx_valid = 1'b0;
   endtask

   task automatic expect_wr(input logic [3:0] a, input logic [7:0] d);
      wr_t t;
      t.a = a;
      t.d = d;
      wr_q.push_back(t);
   endtask

   task automatic frame_start();
      @(negedge SCLK);
      SS = 1'b0;
   endtask

   task automatic frame_end();
      @(negedge SCLK);
      SS = 1'b1;
      @(negedge SCLK);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      RESET     = 1'b1;
      SS        = 1'b1;
      rx_valid  = 1'b0;
      rx_data   = 8'h00;
      status_in = {8'hE7, 8'h16, 8'h15, 8'h14, 8'h13, 8'h12, 8'h5A, 8'h10};
      #12;
      check("reset_tx", 64'(tx_data), 64'h0);
      check("reset_cfg", 64'(cfg_out), 64'h0);
      check("reset_err", 64'(err), 64'h0);
      check("reset_busy", 64'(busy), 64'h0);
      check("reset_strobe", 64'(wr_strobe), 64'h0);
      check("reset_wr_addr", 64'(wr_addr), 64'h0);
      @(negedge SCLK);
      RESET = 1'b0;

      // Write with INC from addr 2
      frame_start();
      send(8'hC2, 0);
      expect_wr(4'd2, 8'h11); send(8'h11, 0);
      expect_wr(4'd3, 8'h22); send(8'h22, 0);
      expect_wr(4'd4, 8'h33); send(8'h33, 0);
      check("busy_in_frame", 64'(busy), 64'h1);
      frame_end();
      check("busy_after_frame", 64'(busy), 64'h0);
      check("cfg_after_wr", 64'(cfg_out), 64'h0000_0033_2211_0000);
      check("err_clean", 64'(err), 64'h0);

      // Read back with INC
      frame_start();
      send(8'h42, 8'h11);
      send(8'h00, 8'h22);
      send(8'h00, 8'h33);
      send(8'h00, 8'h00);
      send(8'h00, 8'h00);
      frame_end();
      check("err_after_read", 64'(err), 64'h0);

      // Write to read-only address
      frame_start();
      send(8'h8F, 0);
      send(8'h55, 0);
      frame_end();
      check("err_ro_write", 64'(err), 64'h1);
      check("cfg_after_ro", 64'(cfg_out), 64'h0000_0033_2211_0000);

      // Status read, no INC then INC
      frame_start();
      send(8'h09, 8'h5A);
      send(8'h00, 8'h5A);
      send(8'h00, 8'h5A);
      send(8'h00, 8'h5A);
      frame_end();
      frame_start();
      send(8'h49, 8'h5A);
      send(8'h00, 8'h12);
      send(8'h00, 8'h13);
      frame_end();
      check("err_sticky", 64'(err), 64'h1);

      // Reset mid-frame with a loaded tx byte
      frame_start();
      send(8'h09, 8'h5A);
      @(posedge SCLK);
      #2 RESET = 1'b1;
      #1;
      check("midrst_cfg", 64'(cfg_out), 64'h0);
      check("midrst_tx", 64'(tx_data), 64'h0);
      check("midrst_err", 64'(err), 64'h0);
      check("midrst_busy", 64'(busy), 64'h0);
      @(negedge SCLK);
      RESET = 1'b0;
      SS    = 1'b1;

      // Write wrap past the last config register
      frame_start();
      send(8'hC7, 0);
      expect_wr(4'd7, 8'hA1); send(8'hA1, 0);
      send(8'hB2, 0);
      frame_end();
      check("err_wrap_drop", 64'(err), 64'h1);
      check("cfg_after_wrap", 64'(cfg_out), 64'hA100_0000_0000_0000);

      // Seed reg0, then read INC from 15 wrapping to 0
      frame_start();
      send(8'h80, 0);
      expect_wr(4'd0, 8'h3C); send(8'h3C, 0);
      frame_end();
      frame_start();
      send(8'h4F, 8'hE7);
      send(8'h00, 8'h3C);
      send(8'h00, 8'h00);
      frame_end();

      // Non-INC write rewrites the same register
      frame_start();
      send(8'h81, 0);
      expect_wr(4'd1, 8'h77); send(8'h77, 0);
      expect_wr(4'd1, 8'h88); send(8'h88, 0);
      frame_end();
      check("cfg1_rewrite", 64'(cfg_out[15:8]), 64'h88);

      // Abort a write frame with a partial data byte
      frame_start();
      send(8'h81, 0);
      repeat (4) @(negedge SCLK);
      check("busy_before_abort", 64'(busy), 64'h1);
      frame_end();
      check("busy_after_abort", 64'(busy), 64'h0);
      check("cfg1_after_abort", 64'(cfg_out[15:8]), 64'h88);

      // Abort a read frame: tx must clear
      frame_start();
      send(8'h47, 8'hA1);
      send(8'h00, 8'h10);
      frame_end();
      check("tx_after_abort", 64'(tx_data), 64'h0);
      check("busy_after_rd_abort", 64'(busy), 64'h0);

      repeat (3) @(negedge SCLK);
      check("wr_queue_drained", 64'(wr_q.size()), 64'h0);
      check("tx_queue_drained", 64'(tx_q.size()), 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
